uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// Shares the UART transmit FIFO write port among N byte-stream requesters (CPU store path, debug
// console, boot monitor). Round-robin grant per packet; grant held until the requester's last byte,
// so packets never interleave on the serial line. Writes are throttled by FIFO occupancy, so no byte
// is dropped. Sits between the requesters and the UART wrapper's TX buffer write port.
// PARAMETERS
// N            3    number of requesters, 2..8
// DEPTH        7    log2 of TX FIFO capacity; must match FIFO DEPTH (capacity 2**DEPTH)
// LOCK_TIMEOUT 255  idle cycles inside a packet before grant is forcibly released, 1..65535
// PORTS
// clk          in   1        system clock
// rstn         in   1        asynchronous reset, active low
// en           in   1        arbiter enable; low = no new grants
// req_valid    in   N        requester i has a byte on req_data
// req_data     in   8*N      byte of requester i at [8i+7:8i]
// req_last     in   N        byte of requester i ends its packet
// req_ready    out  N        byte of requester i accepted this cycle (valid&ready)
// fifo_load    in   DEPTH+1  TX FIFO occupancy count
// fifo_din     out  8        byte to TX FIFO
// fifo_we      out  1        TX FIFO write strobe, one cycle per byte
// owner        out  3        index of current/last grant holder
// busy         out  1        high while a packet is locked
// timeout      out  1        one-cycle pulse when a lock is released by timeout
// BEHAVIOUR
// - Reset (rstn low, async): state IDLE; fifo_we=0, fifo_din=0, owner=0, rr pointer=0, busy=0,
//   timeout=0, timeout counter=0; req_ready=0 (combinational, 0 whenever not LOCKED).
// - States: IDLE, LOCKED.
// - IDLE: if en && |req_valid, grant first valid requester searching ptr, ptr+1, ... mod N;
//   register owner, go LOCKED next edge. No byte transferred in the grant cycle.
// - LOCKED: req_ready[owner] = space_ok; all other req_ready bits 0.
//   space_ok = (fifo_load + fifo_we) < 2**DEPTH, computed at DEPTH+2 bits (fifo_we counts the
//   write in flight that fifo_load has not yet reflected).
// - Transfer (valid&ready on owner): next edge fifo_din<=byte, fifo_we<=1; else fifo_we<=0.
//   Latency requester->FIFO write strobe = 1 cycle; sustained 1 byte/cycle while FIFO not full.
// - Transfer with req_last: next edge IDLE, busy<=0, ptr<=(owner+1) mod N. A new grant may
//   be issued in that IDLE cycle, giving 1 idle cycle between packets.
// - Timeout counter: cleared on every transfer and on entering LOCKED; increments while LOCKED
//   with req_valid[owner]=0. FIFO-full stall (valid=1, space_ok=0) does not count. At
//   LOCK_TIMEOUT: go IDLE, ptr<=owner+1, timeout pulses 1 cycle.
// - en low in LOCKED: current packet completes normally; no new grant afterwards.
// - owner holds its value in IDLE (last holder) for status reads.
// - Single requester: re-granted every packet with 1-cycle gap; others never starved (each waits
//   at most N-1 packets).
// - Reset mid-packet: lock abandoned, pending fifo_we cleared; bytes already written stay in FIFO.
// TESTING
// - Reset then N=3, req0 sends 4-byte packet 0x41..0x44, last on 0x44 -> grant cycle then
//   fifo_we 4 consecutive cycles with 0x41..0x44; busy falls after last; owner=0.
// - req0,req1,req2 all valid 2-byte packets continuously -> packet order 0,1,2,0,...; no
//   interleaving of bytes from different requesters within a packet.
// - fifo_load=2**DEPTH-1, req1 streaming -> exactly one write, then req_ready=0 until load
//   drops; no write when load=2**DEPTH; timeout never fires during stall.
// - req2 granted, sends 1 byte without last then drops valid -> after LOCK_TIMEOUT cycles
//   timeout pulses once, state IDLE, next grant goes to req0.
// - en dropped mid-packet of req1 -> packet completes; with all valids high no further grant
//   until en=1.
// - rstn asserted during packet byte 2 of 5 -> fifo_we=0 immediately, busy=0, owner=0; after
//   release arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin per-packet arbiter driving the UART TX FIFO write port; grant held until the owner's last byte.
// Requester byte -> fifo_we latency 1 cycle; owner ready throttled by FIFO occupancy including the in-flight write.
module uart_tx_arbiter #(
  parameter int N            = 3,
  parameter int DEPTH        = 7,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  input  logic [DEPTH:0]   fifo_load,
  output logic [7:0]       fifo_din,
  output logic             fifo_we,
  output logic [2:0]       owner,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [DEPTH+1:0] CAP = {2'b01, {DEPTH{1'b0}}};

  state_t       r_state, w_state_nxt;
  logic [2:0]   r_owner, w_owner_nxt;
  logic [2:0]   r_ptr, w_ptr_nxt;
  logic [15:0]  r_tcnt, w_tcnt_nxt;
  logic         r_we, w_we_nxt;
  logic [7:0]   r_din, w_din_nxt;
  logic         r_busy, w_busy_nxt;
  logic         r_timeout, w_timeout_nxt;

  logic [DEPTH+1:0] w_occ;
  logic             w_space_ok;
  logic             w_own_vld, w_own_last;
  logic [7:0]       w_own_dat;
  logic             w_grant_vld;
  logic [2:0]       w_grant_idx;
  logic [2:0]       w_owner_inc;
  logic             w_xfer;

  // fifo_load lags our own write by a cycle, so the pending strobe is counted as occupied space.
  assign w_occ      = {1'b0, fifo_load} + {{(DEPTH+1){1'b0}}, r_we};
  assign w_space_ok = (w_occ < CAP);

  always_comb begin
    w_own_vld  = 1'b0;
    w_own_last = 1'b0;
    w_own_dat  = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (r_owner == 3'(i)) begin
        w_own_vld  = req_valid[i];
        w_own_last = req_last[i];
        w_own_dat  = req_data[8*i +: 8];
      end
    end
  end

  // Pick the valid requester with the smallest rotational distance from the pointer.
  always_comb begin
    int d;
    int best;
    d           = 0;
    best        = N;
    w_grant_idx = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        d = i - int'(r_ptr);
        if (d < 0) d = d + N;
        if (d < best) begin
          best        = d;
          w_grant_idx = 3'(i);
        end
      end
    end
    w_grant_vld = |req_valid;
  end

  assign w_owner_inc = (r_owner == 3'(N-1)) ? 3'd0 : r_owner + 3'd1;
  assign w_xfer      = (r_state == LOCKED) && w_own_vld && w_space_ok;

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_tcnt_nxt    = r_tcnt;
    w_we_nxt      = 1'b0;
    w_din_nxt     = r_din;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    req_ready     = '0;
    case (r_state)
      IDLE: begin
        if (en && w_grant_vld) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_grant_idx;
          w_busy_nxt  = 1'b1;
          w_tcnt_nxt  = 16'd0;
        end
      end
      LOCKED: begin
        for (int i = 0; i < N; i++) begin
          if (r_owner == 3'(i)) req_ready[i] = w_space_ok;
        end
        if (w_xfer) begin
          w_we_nxt   = 1'b1;
          w_din_nxt  = w_own_dat;
          w_tcnt_nxt = 16'd0;
          if (w_own_last) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = w_owner_inc;
          end
        end else if (!w_own_vld) begin
          // A FIFO-full stall keeps valid high and therefore never ages the lock.
          if (r_tcnt == 16'(LOCK_TIMEOUT - 1)) begin
            w_state_nxt   = IDLE;
            w_busy_nxt    = 1'b0;
            w_ptr_nxt     = w_owner_inc;
            w_timeout_nxt = 1'b1;
            w_tcnt_nxt    = 16'd0;
          end else begin
            w_tcnt_nxt = r_tcnt + 16'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_owner   <= 3'd0;
      r_ptr     <= 3'd0;
      r_tcnt    <= 16'd0;
      r_we      <= 1'b0;
      r_din     <= 8'h00;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_we      <= w_we_nxt;
      r_din     <= w_din_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign fifo_we  = r_we;
  assign fifo_din = r_din;
  assign owner    = r_owner;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet streams
// checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N     = 3;
  localparam int DEPTH = 7;
  localparam int LT    = 255;
  localparam int CAP   = 128;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [DEPTH:0]   fifo_load;
  logic [7:0]       fifo_din;
  logic             fifo_we;
  logic [2:0]       owner;
  logic             busy;
  logic             timeout;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_arbiter #(.N(N), .DEPTH(DEPTH), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_load(fifo_load),
    .fifo_din(fifo_din), .fifo_we(fifo_we),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]      = v;
    req_data[8*i +: 8] = d;
    req_last[i]       = l;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    en   = 1'b1;
    clear_reqs();
    fifo_load = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = 24'hA1B2C3;
    fifo_load = '0;
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b0) $display("FAIL rst_we: got %0d want 0", fifo_we); else n_pass++;
    n_chk++; if (fifo_din !== 8'h00) $display("FAIL rst_din: got %h want 00", fifo_din); else n_pass++;
    n_chk++; if (owner !== 3'd0) $display("FAIL rst_owner: got %0d want 0", owner); else n_pass++;
    n_chk++; if (busy !== 1'b0 || timeout !== 1'b0) $display("FAIL rst_busy_to: got %b%b want 00", busy, timeout); else n_pass++;
    n_chk++; if (req_ready !== 3'b000) $display("FAIL rst_ready: got %b want 000", req_ready); else n_pass++;
    tick();
    rstn = 1'b1;
    clear_reqs();
    tick();
  endtask

  task automatic test_single_packet();
    int bad;
    apply_reset();
    bad = 0;
    set_req(0, 1'b1, 8'h41, 1'b0);
    @(negedge clk);
    n_chk++; if (req_ready !== 3'b000 || busy !== 1'b0) $display("FAIL sp_grant_cycle: got ready=%b busy=%b want 000/0", req_ready, busy); else n_pass++;
    tick();
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1'b1, 8'(8'h41 + b), (b == 3));
      @(negedge clk);
      if (req_ready !== 3'b001 || busy !== 1'b1) bad++;
      if (b > 0 && (fifo_we !== 1'b1 || fifo_din !== 8'(8'h41 + b - 1))) bad++;
      tick();
    end
    n_chk++; if (bad != 0) $display("FAIL sp_stream: got %0d bad cycles want 0", bad); else n_pass++;
    set_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b1 || fifo_din !== 8'h44) $display("FAIL sp_last: got we=%b din=%h want 1/44", fifo_we, fifo_din); else n_pass++;
    n_chk++; if (busy !== 1'b0 || owner !== 3'd0) $display("FAIL sp_release: got busy=%b owner=%0d want 0/0", busy, owner); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b0) $display("FAIL sp_no_extra: got we=%b want 0", fifo_we); else n_pass++;
    tick();
  endtask

  // plen=0 gives random packet lengths; noise adds owner valid bubbles and FIFO-full stalls.
  task automatic run_stream(input int plen, input bit noise, input string tag);
    logic [8:0]  rq [N][$];
    logic [8:0]  mq [N][$];
    logic [10:0] exp_q [$];
    logic [10:0] e;
    logic [N-1:0] acc;
    int gap [N];
    int len, ptr, sel, cycles, r;
    logic [7:0] bt;
    apply_reset();
    for (int q = 0; q < N; q++) begin
      gap[q] = 0;
      for (int p = 0; p < 2 + int'($urandom % 3); p++) begin
        len = (plen != 0) ? plen : 1 + int'($urandom % 4);
        for (int b = 0; b < len; b++) begin
          bt = 8'($urandom);
          rq[q].push_back({(b == len - 1), bt});
        end
      end
      mq[q] = rq[q];
    end
    ptr = 0;
    while (mq[0].size() + mq[1].size() + mq[2].size() != 0) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        if (sel < 0 && mq[(ptr + k) % N].size() != 0) sel = (ptr + k) % N;
      end
      do begin
        e = {3'(sel), mq[sel][0][7:0]};
        exp_q.push_back(e);
      end while (mq[sel].pop_front() & 9'h100 ? 1'b0 : 1'b1);
      ptr = (sel + 1) % N;
    end
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 4000) begin
      for (int q = 0; q < N; q++) begin
        if (rq[q].size() != 0 && gap[q] == 0) set_req(q, 1'b1, rq[q][0][7:0], rq[q][0][8]);
        else set_req(q, 1'b0, 8'h00, 1'b0);
      end
      r = int'($urandom % 4);
      fifo_load = !noise ? '0 : (r == 0) ? 8'(CAP) : (r == 1) ? 8'(CAP - 1) : (r == 2) ? 8'd0 : 8'd64;
      @(negedge clk);
      if (fifo_we === 1'b1) begin
        n_chk++;
        e = exp_q.pop_front();
        if ({owner, fifo_din} !== e)
          $display("FAIL %s_byte: got owner=%0d byte=%h want owner=%0d byte=%h", tag, owner, fifo_din, e[10:8], e[7:0]);
        else n_pass++;
      end
      acc = req_valid & req_ready;
      tick();
      cycles++;
      for (int q = 0; q < N; q++) begin
        if (acc[q]) begin
          gap[q] = (noise && !rq[q][0][8]) ? int'($urandom % 3) : 0;
          void'(rq[q].pop_front());
        end else if (gap[q] > 0) begin
          gap[q]--;
        end
      end
    end
    n_chk++; if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d bytes missing want 0", tag, exp_q.size()); else n_pass++;
    clear_reqs();
    fifo_load = '0;
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    run_stream(2, 1'b0, "rr");
  endtask

  task automatic test_random_stream();
    for (int s = 0; s < 3; s++) run_stream(0, 1'b1, "rnd");
  endtask

  task automatic test_fifo_full();
    int bad;
    apply_reset();
    fifo_load = 8'(CAP - 1);
    set_req(1, 1'b1, 8'h55, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    n_chk++; if (req_ready !== 3'b010) $display("FAIL full_ready_one: got %b want 010", req_ready); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b1 || fifo_din !== 8'h55) $display("FAIL full_write: got we=%b din=%h want 1/55", fifo_we, fifo_din); else n_pass++;
    n_chk++; if (req_ready !== 3'b000) $display("FAIL full_inflight: got %b want 000", req_ready); else n_pass++;
    tick();
    fifo_load = 8'(CAP);
    bad = 0;
    repeat (LT + 20) begin
      @(negedge clk);
      if (req_ready !== 3'b000 || fifo_we !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    n_chk++; if (bad != 0) $display("FAIL full_stall: got %0d bad cycles want 0", bad); else n_pass++;
    fifo_load = 8'(CAP - 4);
    set_req(1, 1'b1, 8'h66, 1'b1);
    @(negedge clk);
    n_chk++; if (req_ready !== 3'b010) $display("FAIL full_resume: got %b want 010", req_ready); else n_pass++;
    tick();
    clear_reqs();
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b1 || fifo_din !== 8'h66 || busy !== 1'b0) $display("FAIL full_end: got we=%b din=%h busy=%b want 1/66/0", fifo_we, fifo_din, busy); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int hit;
    int pulses;
    apply_reset();
    set_req(2, 1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    n_chk++; if (owner !== 3'd2 || req_ready !== 3'b100) $display("FAIL to_grant: got owner=%0d ready=%b want 2/100", owner, req_ready); else n_pass++;
    tick();
    clear_reqs();
    hit = 0;
    for (int n = 1; n <= LT + 10; n++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        hit = n;
        break;
      end
      if (busy !== 1'b1) hit = -n;
      if (hit < 0) break;
      tick();
    end
    n_chk++; if (hit != LT + 1) $display("FAIL to_cycle: got %0d want %0d", hit, LT + 1); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL to_idle: got busy=%b want 0", busy); else n_pass++;
    set_req(0, 1'b1, 8'h11, 1'b1);
    set_req(1, 1'b1, 8'h22, 1'b1);
    set_req(2, 1'b1, 8'h33, 1'b1);
    tick();
    pulses = 0;
    @(negedge clk);
    if (timeout !== 1'b0) pulses++;
    n_chk++; if (pulses != 0) $display("FAIL to_single_pulse: got %0d extra want 0", pulses); else n_pass++;
    n_chk++; if (owner !== 3'd0 || busy !== 1'b1) $display("FAIL to_next_grant: got owner=%0d busy=%b want 0/1", owner, busy); else n_pass++;
    clear_reqs();
    tick();
  endtask

  task automatic test_en_drop();
    int bad;
    apply_reset();
    set_req(1, 1'b1, 8'hB1, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    n_chk++; if (owner !== 3'd1) $display("FAIL en_grant: got owner=%0d want 1", owner); else n_pass++;
    tick();
    en = 1'b0;
    set_req(0, 1'b1, 8'hC0, 1'b1);
    set_req(2, 1'b1, 8'hC2, 1'b1);
    set_req(1, 1'b1, 8'hB2, 1'b0);
    tick();
    set_req(1, 1'b1, 8'hB3, 1'b1);
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b1 || fifo_din !== 8'hB2 || owner !== 3'd1) $display("FAIL en_continue: got we=%b din=%h owner=%0d want 1/b2/1", fifo_we, fifo_din, owner); else n_pass++;
    tick();
    set_req(1, 1'b1, 8'hB9, 1'b1);
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b1 || fifo_din !== 8'hB3 || busy !== 1'b0) $display("FAIL en_complete: got we=%b din=%h busy=%b want 1/b3/0", fifo_we, fifo_din, busy); else n_pass++;
    tick();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_ready !== 3'b000 || fifo_we !== 1'b0) bad++;
      tick();
    end
    n_chk++; if (bad != 0) $display("FAIL en_hold: got %0d bad cycles want 0", bad); else n_pass++;
    en = 1'b1;
    tick();
    @(negedge clk);
    n_chk++; if (owner !== 3'd2 || busy !== 1'b1) $display("FAIL en_regrant: got owner=%0d busy=%b want 2/1", owner, busy); else n_pass++;
    clear_reqs();
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(0, 1'b1, 8'h01, 1'b1);
    tick();
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b1, 8'hD1, 1'b0);
    tick();
    tick();
    set_req(1, 1'b1, 8'hD2, 1'b0);
    @(negedge clk);
    n_chk++; if (fifo_we !== 1'b1 || owner !== 3'd1 || fifo_din !== 8'hD1) $display("FAIL rm_pre: got we=%b owner=%0d din=%h want 1/1/d1", fifo_we, owner, fifo_din); else n_pass++;
    rstn = 1'b0;
    #1;
    n_chk++; if (fifo_we !== 1'b0 || busy !== 1'b0 || owner !== 3'd0) $display("FAIL rm_async: got we=%b busy=%b owner=%0d want 0/0/0", fifo_we, busy, owner); else n_pass++;
    tick();
    rstn = 1'b1;
    req_valid = '1;
    req_last  = '1;
    tick();
    @(negedge clk);
    n_chk++; if (owner !== 3'd0 || busy !== 1'b1) $display("FAIL rm_restart: got owner=%0d busy=%b want 0/1", owner, busy); else n_pass++;
    clear_reqs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    en   = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_load = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_fifo_full();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
